imem_fetch_ctrl: RTL and testbench
==================================

Name: imem_fetch_ctrl

Overview:
Fetch sequencer that owns the program counter driving the word-indexed, combinational-read instruction memory. It presents the PC, captures the returned instruction into a one-entry output register with a valid/ready handshake toward decode, and applies branch redirects with flush. It detects an all-zero halt word and stops fetching; a start pulse begins or resumes execution.

Parameters:
ADDR_W, 5, PC width in words; memory depth is 2^ADDR_W and the PC wraps modulo that depth.
DATA_W, 32, instruction width.
RESET_PC, 0, word address loaded into the PC at reset.
HALT_WORD, 32'h0000_0000, instruction value that stops fetching.
CNT_W, 16, width of the fetch counter.

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  reset
start  in  1  single-cycle pulse: leave IDLE or HALT and enter RUN
imem_pc  out  32  address to instruction memory, word index; equals the zero-extended PC register
imem_instr  in  DATA_W  combinational read data for imem_pc
redirect_valid  in  1  branch/jump taken this cycle
redirect_pc  in  32  target word index; only bits [ADDR_W-1:0] used
out_valid  out  1  out_instr/out_pc hold a valid fetched instruction
out_ready  in  1  decode accepts when out_valid && out_ready
out_instr  out  DATA_W  fetched instruction
out_pc  out  32  word address of out_instr, zero-extended
halted  out  1  high while in HALT
fetch_count  out  CNT_W  number of instructions delivered into the output register; saturates

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (rst_n).
  - Reset values: state=IDLE, PC=RESET_PC, out_valid=0, out_instr=0, out_pc=0, halted=0, fetch_count=0.
  - Reset mid-fetch discards the output register immediately with no handshake.
- States:
  - IDLE: no fetch. start -> RUN next cycle; the first fetch happens in the first RUN cycle.
  - RUN: fetch enabled. Start is ignored.
  - HALT: no fetch; halted=1. start -> RUN and resumes at the current PC.
- Fetch condition: state==RUN && !redirect_valid && (!out_valid || out_ready).
- On a fetch with imem_instr != HALT_WORD:
  - out_instr <= imem_instr, out_pc <= PC, out_valid <= 1.
  - PC <= (PC+1) mod 2^ADDR_W, so the last word wraps to 0.
  - fetch_count increments and saturates at 2^CNT_W-1.
- On a fetch with imem_instr == HALT_WORD:
  - The word is not delivered and the PC does not advance (it stays on the halt word).
  - state -> HALT; out_valid <= 0, which is legal because the fetch condition guarantees any pending entry is being consumed this cycle.
- Stall: out_valid && !out_ready in RUN holds PC, out_* and fetch_count unchanged.
- Redirect, any state, highest priority:
  - PC <= redirect_pc[ADDR_W-1:0]; out_valid <= 0 (flush, even if out_ready=1); no fetch that cycle; state unchanged.
  - The first instruction from the target is delivered the next fetch-eligible cycle (one-bubble penalty).
- start && redirect_valid in the same cycle from IDLE/HALT: PC takes the redirect target and state -> RUN.
- Consumption without fetch (out_valid && out_ready with state!=RUN): out_valid <= 0.
- Throughput: one instruction per cycle when out_ready is held high and there is no redirect.
- imem_pc is a direct register output with no combinational path from any input.

Decomposition:
- Shared package fetch_pkg:
  - state enum {IDLE, RUN, HALT}, encoded in 2 bits.
  - HALT_WORD default constant.
  - Default ADDR_W.
- No sub-module needed. PC, output register and state machine live in one module of roughly 150 lines.

Test Plan:
- Reset, then start at cycle 3, memory preloaded with words 0..9 and zeros beyond, out_ready=1 -> out_pc goes 0,1,...,9 on consecutive cycles. The fetch at PC=10 sees 0, so halted=1, fetch_count=10, imem_pc holds 10.
- Hold out_ready=0 for 4 cycles while out_valid=1 at out_pc=2 -> out_pc/out_instr/imem_pc are unchanged for 4 cycles. After out_ready returns to 1, out_pc=3 follows next cycle with no loss or duplication.
- Assert redirect_valid with redirect_pc=0 while out_pc=9 is valid -> out_valid=0 the next cycle (flush), then out_pc=0. fetch_count does not count the flushed cycle.
- With ADDR_W=5, redirect_pc=31 and memory[31] non-zero -> out_pc=31 is delivered, then imem_pc wraps to 0 and out_pc=0.
- In HALT at PC=10, pulse start and redirect_valid together with redirect_pc=4 -> state RUN, halted=0, next delivered out_pc=4.
- Drop rst_n asynchronously mid-stream with out_valid=1 -> out_valid, halted and fetch_count are 0 and imem_pc=RESET_PC before the next clock edge. No fetch happens until a new start.

Source files
------------

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared types and defaults for the instruction fetch sequencer
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  // Fetch sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  // Default PC width in words (memory depth 2^DEF_ADDR_W)
  localparam int DEF_ADDR_W = 5;

  // Instruction value that stops fetching
  localparam logic [31:0] DEF_HALT_WORD = 32'h0000_0000;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/imem_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : imem_fetch_ctrl
//  Description : Fetch sequencer owning the PC into a combinational-read
//                instruction memory. Captures each returned word into a
//                one-entry output register with valid/ready toward decode,
//                applies branch redirects with flush, and halts on HALT_WORD.
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int                 ADDR_W    = DEF_ADDR_W,
  parameter int                 DATA_W    = 32,
  parameter int                 RESET_PC  = 0,
  parameter logic [DATA_W-1:0]  HALT_WORD = DATA_W'(DEF_HALT_WORD),
  parameter int                 CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [31:0]       imem_pc,
  input  logic [DATA_W-1:0] imem_instr,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [31:0]       out_pc,
  output logic              halted,
  output logic [CNT_W-1:0]  fetch_count
);

  localparam logic [ADDR_W-1:0] C_RESET_PC = ADDR_W'(RESET_PC);
  localparam logic [CNT_W-1:0]  C_CNT_MAX  = {CNT_W{1'b1}};

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_instr_q, out_instr_d;
  logic [ADDR_W-1:0] out_pc_q, out_pc_d;
  logic [CNT_W-1:0]  fetch_count_q, fetch_count_d;

  logic              w_fetch;
  logic              w_is_halt;

  // Only the low ADDR_W bits of the redirect target address the memory
  logic              unused_redirect_hi;
  assign unused_redirect_hi = ^redirect_pc[31:ADDR_W];

  // A fetch happens when running, not redirected, and the output slot frees up
  assign w_fetch   = (state_q == ST_RUN) && !redirect_valid && (!out_valid_q || out_ready);
  assign w_is_halt = (imem_instr == HALT_WORD);

  // Next-state logic: redirect dominates, otherwise consume / fetch / start
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    out_valid_d   = out_valid_q;
    out_instr_d   = out_instr_q;
    out_pc_d      = out_pc_q;
    fetch_count_d = fetch_count_q;

    // Decode draining the slot frees it regardless of state
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (redirect_valid) begin
      // Flush the pending entry even if it is being accepted this cycle
      pc_d        = redirect_pc[ADDR_W-1:0];
      out_valid_d = 1'b0;
      if (start && (state_q != ST_RUN)) begin
        state_d = ST_RUN;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_RUN;
          end
        end
        ST_HALT: begin
          // Resume at the PC still parked on the halt word
          if (start) begin
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_fetch) begin
            if (w_is_halt) begin
              // Halt word is not delivered and the PC stays on it
              state_d     = ST_HALT;
              out_valid_d = 1'b0;
            end else begin
              out_instr_d = imem_instr;
              out_pc_d    = pc_q;
              out_valid_d = 1'b1;
              pc_d        = pc_q + ADDR_W'(1);
              if (fetch_count_q != C_CNT_MAX) begin
                fetch_count_d = fetch_count_q + CNT_W'(1);
              end
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State, PC and output register; reset discards any pending entry at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      pc_q          <= C_RESET_PC;
      out_valid_q   <= 1'b0;
      out_instr_q   <= '0;
      out_pc_q      <= '0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      out_valid_q   <= out_valid_d;
      out_instr_q   <= out_instr_d;
      out_pc_q      <= out_pc_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  // All outputs come straight from registers
  assign imem_pc     = 32'(pc_q);
  assign out_valid   = out_valid_q;
  assign out_instr   = out_instr_q;
  assign out_pc      = 32'(out_pc_q);
  assign halted      = (state_q == ST_HALT);
  assign fetch_count = fetch_count_q;

endmodule : imem_fetch_ctrl
`default_nettype wire

// File: tb/tb_imem_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_fetch_ctrl
//  Description : Directed self-checking bench for imem_fetch_ctrl
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] imem_pc;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        halted;
  logic [15:0] fetch_count;

  logic [31:0] mem [0:31];

  int checks   = 0;
  int failures = 0;

  imem_fetch_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .imem_pc        (imem_pc),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .halted         (halted),
    .fetch_count    (fetch_count)
  );

  always #5 clk = ~clk;

  // Combinational-read instruction memory
  assign imem_instr = mem[imem_pc[4:0]];

  function automatic logic [31:0] word_of(input int idx);
    return 32'hC0DE_0000 | 32'(idx + 1);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'd0;
    out_ready = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'd0;
    out_ready = 1'b1;
    #3;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0h exp=0", out_valid); end
    checks++; if (out_instr !== 32'd0) begin failures++; $display("FAIL reset_out_instr got=%0h exp=0", out_instr); end
    checks++; if (out_pc !== 32'd0) begin failures++; $display("FAIL reset_out_pc got=%0h exp=0", out_pc); end
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%0h exp=0", halted); end
    checks++; if (fetch_count !== 16'd0) begin failures++; $display("FAIL reset_fetch_count got=%0d exp=0", fetch_count); end
    checks++; if (imem_pc !== 32'd0) begin failures++; $display("FAIL reset_imem_pc got=%0h exp=0", imem_pc); end
    step();
    rst_n = 1'b1;
    step();
    step();
    // IDLE must not fetch without start
    checks++; if (out_valid !== 1'b0 || imem_pc !== 32'd0) begin failures++; $display("FAIL idle_no_fetch got valid=%0h pc=%0h exp valid=0 pc=0", out_valid, imem_pc); end
  endtask

  task automatic test_stream();
    do_start();
    // First fetch only happens in the first RUN cycle
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL start_latency got=%0h exp=0", out_valid); end
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'(i) || out_instr !== word_of(i)) begin
        failures++;
        $display("FAIL stream_%0d got valid=%0h pc=%0h instr=%0h exp valid=1 pc=%0h instr=%0h",
                 i, out_valid, out_pc, out_instr, i, word_of(i));
      end
    end
    step();
    checks++; if (halted !== 1'b1) begin failures++; $display("FAIL halt_flag got=%0h exp=1", halted); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL halt_out_valid got=%0h exp=0", out_valid); end
    checks++; if (fetch_count !== 16'd10) begin failures++; $display("FAIL halt_fetch_count got=%0d exp=10", fetch_count); end
    checks++; if (imem_pc !== 32'd10) begin failures++; $display("FAIL halt_imem_pc got=%0h exp=a", imem_pc); end
    step();
    step();
    checks++; if (halted !== 1'b1 || imem_pc !== 32'd10 || fetch_count !== 16'd10) begin failures++; $display("FAIL halt_hold got halted=%0h pc=%0h cnt=%0d exp halted=1 pc=a cnt=10", halted, imem_pc, fetch_count); end
  endtask

  task automatic test_halt_resume();
    start = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'd4;
    step();
    start = 1'b0;
    redirect_valid = 1'b0;
    checks++; if (halted !== 1'b0 || out_valid !== 1'b0 || imem_pc !== 32'd4) begin failures++; $display("FAIL resume_redirect got halted=%0h valid=%0h pc=%0h exp halted=0 valid=0 pc=4", halted, out_valid, imem_pc); end
    step();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'd4 || out_instr !== word_of(4)) begin failures++; $display("FAIL resume_first got valid=%0h pc=%0h instr=%0h exp valid=1 pc=4 instr=%0h", out_valid, out_pc, out_instr, word_of(4)); end
    checks++; if (fetch_count !== 16'd11) begin failures++; $display("FAIL resume_count got=%0d exp=11", fetch_count); end
    step();
    checks++; if (out_pc !== 32'd5) begin failures++; $display("FAIL resume_second got=%0h exp=5", out_pc); end
  endtask

  task automatic test_stall();
    do_reset();
    do_start();
    step();
    step();
    step();
    checks++; if (out_pc !== 32'd2 || out_valid !== 1'b1) begin failures++; $display("FAIL stall_setup got pc=%0h valid=%0h exp pc=2 valid=1", out_pc, out_valid); end
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'd2 || out_instr !== word_of(2) ||
          imem_pc !== 32'd3 || fetch_count !== 16'd3) begin
        failures++;
        $display("FAIL stall_hold_%0d got valid=%0h pc=%0h instr=%0h ipc=%0h cnt=%0d exp 1 2 %0h 3 3",
                 i, out_valid, out_pc, out_instr, imem_pc, fetch_count, word_of(2));
      end
    end
    out_ready = 1'b1;
    step();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'd3 || out_instr !== word_of(3)) begin failures++; $display("FAIL stall_release got valid=%0h pc=%0h exp valid=1 pc=3", out_valid, out_pc); end
    step();
    checks++; if (out_pc !== 32'd4 || fetch_count !== 16'd5) begin failures++; $display("FAIL stall_after got pc=%0h cnt=%0d exp pc=4 cnt=5", out_pc, fetch_count); end
  endtask

  task automatic test_redirect();
    for (int i = 0; i < 5; i++) step();
    checks++; if (out_pc !== 32'd9 || out_valid !== 1'b1 || fetch_count !== 16'd10) begin failures++; $display("FAIL redir_setup got pc=%0h valid=%0h cnt=%0d exp pc=9 valid=1 cnt=10", out_pc, out_valid, fetch_count); end
    redirect_valid = 1'b1;
    redirect_pc = 32'd0;
    step();
    redirect_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || imem_pc !== 32'd0 || halted !== 1'b0) begin failures++; $display("FAIL redir_flush got valid=%0h ipc=%0h halted=%0h exp valid=0 ipc=0 halted=0", out_valid, imem_pc, halted); end
    checks++; if (fetch_count !== 16'd10) begin failures++; $display("FAIL redir_count got=%0d exp=10", fetch_count); end
    step();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'd0 || out_instr !== word_of(0) || fetch_count !== 16'd11) begin failures++; $display("FAIL redir_target got valid=%0h pc=%0h cnt=%0d exp valid=1 pc=0 cnt=11", out_valid, out_pc, fetch_count); end
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFF;
    step();
    redirect_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || imem_pc !== 32'd31) begin failures++; $display("FAIL wrap_redirect got valid=%0h ipc=%0h exp valid=0 ipc=1f", out_valid, imem_pc); end
    step();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'd31 || out_instr !== mem[31] || imem_pc !== 32'd0) begin failures++; $display("FAIL wrap_last got valid=%0h pc=%0h instr=%0h ipc=%0h exp valid=1 pc=1f instr=%0h ipc=0", out_valid, out_pc, out_instr, imem_pc, mem[31]); end
    step();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'd0 || imem_pc !== 32'd1 || fetch_count !== 16'd13) begin failures++; $display("FAIL wrap_zero got valid=%0h pc=%0h ipc=%0h cnt=%0d exp valid=1 pc=0 ipc=1 cnt=13", out_valid, out_pc, imem_pc, fetch_count); end
  endtask

  task automatic test_async_reset();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL areset_setup got=%0h exp=1", out_valid); end
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || halted !== 1'b0 || fetch_count !== 16'd0 || imem_pc !== 32'd0) begin failures++; $display("FAIL areset_immediate got valid=%0h halted=%0h cnt=%0d ipc=%0h exp 0 0 0 0", out_valid, halted, fetch_count, imem_pc); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step();
    checks++; if (out_valid !== 1'b0 || imem_pc !== 32'd0 || fetch_count !== 16'd0) begin failures++; $display("FAIL areset_no_fetch got valid=%0h ipc=%0h cnt=%0d exp 0 0 0", out_valid, imem_pc, fetch_count); end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = (i < 10) ? word_of(i) : 32'd0;
    mem[31] = 32'hDEAD_BEEF;
    test_reset();
    test_stream();
    test_halt_resume();
    test_stall();
    test_redirect();
    test_wrap();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound so the run always terminates
  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule : tb_imem_fetch_ctrl
`default_nettype wire
